// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the 8-requester round-robin mux arbiter.
// The hold-limit option is enabled by defining MUX8_ARB_HOLD_LIMIT_EN.
package mux8_arb_pkg;

  localparam int N_REQ    = 8;
  localparam int SEL_W    = 3;
  localparam int HOLD_W   = 4;
  // Transfers one owner may complete while others wait; legal range 1..15.
  localparam int MAX_HOLD = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/Mux_8x1.sv
// Existing 8:1 single-bit datapath mux; y follows d[sel] combinationally.
module Mux_8x1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux8_rr_pick.sv
// Combinational round-robin pick: first eligible request scanning upward
// from ptr, wrapping modulo N_REQ. Bits set in excl are never eligible.
module mux8_rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [N_REQ-1:0] eligible;
  logic [SEL_W-1:0] idx;

  assign eligible = req & ~excl;

  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && eligible[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared Mux_8x1 instance.
// Define MUX8_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD transfers.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             data_out,
  output logic             out_valid,
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_d, ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_d, excl;
  logic [SEL_W-1:0] winner;
  logic             pick_any, new_grant, xfer;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  assign busy = (state_q == GRANT);
  assign xfer = out_valid & out_ready;
  // The current owner is never a candidate, which covers both the
  // releasing bit and the forced-rotation case.
  assign excl = grant;

  mux8_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .excl   (excl),
    .winner (winner),
    .any    (pick_any)
  );

  Mux_8x1 u_mux (
    .d   (data_in),
    .sel (sel),
    .y   (data_out)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel     <= '0;
      grant   <= '0;
      ptr_q   <= '0;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      grant   <= grant_d;
      ptr_q   <= ptr_d;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel;
    grant_d   = grant;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) new_grant = 1'b1;
      end
      GRANT: begin
        if (!req[sel]) begin
          // Release re-picks in the same edge so there is no idle bubble.
          if (pick_any) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
`ifdef MUX8_ARB_HOLD_LIMIT_EN
        else if (xfer && hold_q >= HOLD_W'(MAX_HOLD - 1) && pick_any) begin
          new_grant = 1'b1;
        end else if (xfer && hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (new_grant) begin
      state_d = GRANT;
      sel_d   = winner;
      grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
      ptr_d   = winner + 1'b1;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
      hold_d  = '0;
`endif
    end
  end

  always_comb begin
    out_valid = busy & req[sel];
  end

endmodule
